seconds_bcd_timebase: RTL



---
 rtl/seconds_bcd_timebase.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seconds_bcd_timebase.sv
// rtl/seconds_bcd_timebase.sv - 1 Hz prescaler and two-digit BCD seconds counter
// Optional alarm compare enabled by defining SEC_ALARM_EN.
module seconds_bcd_timebase #(
  parameter int CLK_HZ  = 10000000,
  parameter int PRE_W   = 24,
  parameter int SEC_MOD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       run,
  input  logic       clear,
  output logic       tick,
  output logic       wrap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens
`ifdef SEC_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic [7:0] alarm_bcd,
  output logic       alarm_flag
`endif
);

  if (SEC_MOD < 2 || SEC_MOD > 100) begin : g_bad_mod
    $error("seconds_bcd_timebase: SEC_MOD must be in 2..100");
  end
  if (CLK_HZ < 2) begin : g_bad_clk
    $error("seconds_bcd_timebase: CLK_HZ must be at least 2");
  end
  if ((64'(1) << PRE_W) < 64'(CLK_HZ)) begin : g_bad_pre
    $error("seconds_bcd_timebase: PRE_W too narrow for CLK_HZ");
  end

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [3:0]       LAST_TENS = 4'((SEC_MOD - 1) / 10);
  localparam logic [3:0]       LAST_ONES = 4'((SEC_MOD - 1) % 10);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

`ifdef SEC_ALARM_EN
  logic [7:0] latch_q, latch_d;
  logic       armed_q, armed_d;
  logic       flag_q, flag_d;
`endif

  always_comb begin
    pre_d  = pre_q;
    ones_d = ones_q;
    tens_d = tens_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
`ifdef SEC_ALARM_EN
    latch_d = latch_q;
    armed_d = armed_q;
    flag_d  = flag_q;
`endif
    if (ena) begin
      if (clear) begin
        pre_d  = '0;
        ones_d = 4'd0;
        tens_d = 4'd0;
`ifdef SEC_ALARM_EN
        latch_d = 8'h00;
        armed_d = 1'b0;
        flag_d  = 1'b0;
`endif
      end else begin
        if (run) begin
          if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (tens_q == LAST_TENS && ones_q == LAST_ONES) begin
              ones_d = 4'd0;
              tens_d = 4'd0;
              wrap_d = 1'b1;
            end else if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
`ifdef SEC_ALARM_EN
        // A fresh set takes precedence over a match on the same edge.
        if (alarm_set) begin
          latch_d = alarm_bcd;
          armed_d = 1'b1;
          flag_d  = 1'b0;
        end else if (tick_d && armed_q && ({tens_d, ones_d} == latch_q)) begin
          flag_d  = 1'b1;
          armed_d = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      ones_q <= ones_d;
      tens_q <= tens_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef SEC_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= 8'h00;
      armed_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      latch_q <= latch_d;
      armed_q <= armed_d;
      flag_q  <= flag_d;
    end
  end

  assign alarm_flag = flag_q;
`endif

  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign sec_ones = ones_q;
  assign sec_tens = tens_q;

endmodule
